rx_ppm_slot_demod: RTL and testbench

//  Downstream of the RX pulse-counting stage. Each clk10m cycle it takes one slot count num_in
//  (pulses counted in one half period) and the running window sum num_sum_in.
//  Per sample: adaptive on/off decision -> preamble hunt -> 5-slot PPM symbol demod.

---
 rtl/rx_ppm_pkg.sv | 25 ++
 rtl/rx_sym_fifo.sv | 86 ++++++++
 rtl/rx_ppm_slot_demod.sv | 195 +++++++++++++++++++
 tb/tb_rx_ppm_slot_demod.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ppm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rx_ppm_pkg
// Description : Shared types and constants for the RX PPM slot demodulator.
//               Holds the FSM state type, the symbol width and the FIFO entry.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_ppm_pkg;

  // Slot samples per PPM symbol and the width of a symbol index.
  localparam int SLOTS = 5;
  localparam int SYM_W = $clog2(SLOTS);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  typedef struct packed {
    logic             erase;
    logic [SYM_W-1:0] sym;
  } sym_entry_t;

endpackage
`default_nettype wire

// File: rtl/rx_sym_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_sym_fifo
// Description : FIFO_DEPTH x sym_entry_t valid/ready FIFO with a sticky
//               overflow flag. Simultaneous push and pop is always accepted,
//               including when full.
// Ports       : clk10m, rst_n (sync, active-low)
//               i_push/i_data   - write side (no back-pressure)
//               i_ready         - consumer accepts the head entry
//               o_head/o_valid  - head entry (zero when empty) and valid
//               o_overflow      - a push was dropped on a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sym_fifo
  import rx_ppm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk10m,
  input  logic       rst_n,
  input  logic       i_push,
  input  sym_entry_t i_data,
  input  logic       i_ready,
  output sym_entry_t o_head,
  output logic       o_valid,
  output logic       o_overflow
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  C_DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  sym_entry_t       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_pop   = i_ready && !w_empty;
  // When full, a write is only possible if the head leaves this cycle; the
  // write then lands in the slot being vacated (wr_ptr == rd_ptr).
  assign w_wr    = i_push && (!w_full || w_pop);

  always_ff @(posedge clk10m) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (i_push && !w_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk10m) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid    = !w_empty;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/rx_ppm_slot_demod.sv
`default_nettype none
// ============================================================================
// Module      : rx_ppm_slot_demod
// Description : Per slot sample: adaptive on/off decision, preamble hunt and
//               5-slot PPM symbol demodulation. Symbols leave through a
//               small valid/ready FIFO.
// Ports       : clk10m     - slot-rate clock
//               rst_n      - synchronous active-low reset
//               num_in     - slot pulse count
//               num_sum_in - window sum of the last WIN_LEN counts
//               sym_data/sym_erase/sym_valid/sym_ready - symbol stream
//               locked     - high while demodulating data
//               frame_end  - pulse alongside the last symbol of a frame
//               overflow   - sticky: a symbol was dropped on a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module rx_ppm_slot_demod
  import rx_ppm_pkg::*;
#(
  parameter int                        WIN_LEN    = 250,
  parameter int                        THR_OFS    = 0,
  parameter int                        MIN_CNT    = 4,
  parameter int                        PRE_LEN    = 4,
  parameter logic [PRE_LEN*SYM_W-1:0]  PREAMBLE   = 12'h2A0,
  parameter int                        FRAME_SYMS = 8,
  parameter int                        MAX_ERAS   = 3,
  parameter int                        FIFO_DEPTH = 4
) (
  input  logic             clk10m,
  input  logic             rst_n,
  input  logic [6:0]       num_in,
  input  logic [12:0]      num_sum_in,
  output logic [SYM_W-1:0] sym_data,
  output logic             sym_erase,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             locked,
  output logic             frame_end,
  output logic             overflow
);

  localparam int HIST_W = SLOTS * PRE_LEN;
  localparam int SCNT_W = $clog2(FRAME_SYMS + 1);
  localparam int ECNT_W = $clog2(MAX_ERAS + 1);

  // One-hot image of the preamble: symbol k sets bit k*SLOTS + value.
  function automatic logic [HIST_W-1:0] f_pre_image(input logic [PRE_LEN*SYM_W-1:0] pre);
    logic [HIST_W-1:0] img;
    img = '0;
    for (int k = 0; k < PRE_LEN; k++) begin
      img[k*SLOTS + int'(pre[k*SYM_W +: SYM_W])] = 1'b1;
    end
    return img;
  endfunction

  localparam logic [HIST_W-1:0] C_PRE_IMAGE = f_pre_image(PREAMBLE);
  localparam logic [SYM_W-1:0]  C_LAST_SLOT = SYM_W'(SLOTS - 1);
  localparam logic [SCNT_W-1:0] C_LAST_SYM  = SCNT_W'(FRAME_SYMS - 1);
  localparam logic [ECNT_W-1:0] C_LAST_ERAS = ECNT_W'(MAX_ERAS - 1);

  state_t            r_state,    w_state_nx;
  logic [HIST_W-1:0] r_hist,     w_hist_nx;
  logic [SYM_W-1:0]  r_slot_cnt, w_slot_nx;
  logic [SCNT_W-1:0] r_sym_cnt,  w_sym_nx;
  logic [ECNT_W-1:0] r_eras_cnt, w_eras_nx;
  logic              r_have,     w_have_nx;
  logic [6:0]        r_best_val, w_best_val_nx;
  logic [SYM_W-1:0]  r_best_idx, w_best_idx_nx;
  logic              r_frame_end, w_frame_end_nx;

  logic [15:0]       w_scaled;
  logic [15:0]       w_thresh;
  logic              w_on;
  logic [HIST_W-1:0] w_hist_shift;
  logic              w_base_have;
  logic [6:0]        w_base_val;
  logic              w_push;
  sym_entry_t        w_push_entry;
  sym_entry_t        w_head;

  // num_in is scaled by the window length rather than dividing the sum, so
  // the compare is against the window average; equality counts as off.
  assign w_scaled     = 16'(num_in) * 16'(WIN_LEN);
  assign w_thresh     = 16'(num_sum_in) + 16'(THR_OFS);
  assign w_on         = (w_scaled > w_thresh) && (num_in >= 7'(MIN_CNT));
  // Oldest sample sits in bit 0, newest enters at the top.
  assign w_hist_shift = {w_on, r_hist[HIST_W-1:1]};
  // Argmax tracking restarts at slot 0 of every symbol.
  assign w_base_have  = (r_slot_cnt == '0) ? 1'b0 : r_have;
  assign w_base_val   = (r_slot_cnt == '0) ? 7'd0 : r_best_val;

  always_ff @(posedge clk10m) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_hist      <= '0;
      r_slot_cnt  <= '0;
      r_sym_cnt   <= '0;
      r_eras_cnt  <= '0;
      r_have      <= 1'b0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_frame_end <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_hist      <= w_hist_nx;
      r_slot_cnt  <= w_slot_nx;
      r_sym_cnt   <= w_sym_nx;
      r_eras_cnt  <= w_eras_nx;
      r_have      <= w_have_nx;
      r_best_val  <= w_best_val_nx;
      r_best_idx  <= w_best_idx_nx;
      r_frame_end <= w_frame_end_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_hist_nx      = r_hist;
    w_slot_nx      = r_slot_cnt;
    w_sym_nx       = r_sym_cnt;
    w_eras_nx      = r_eras_cnt;
    w_have_nx      = w_base_have;
    w_best_val_nx  = w_base_val;
    w_best_idx_nx  = r_best_idx;
    w_frame_end_nx = 1'b0;
    w_push         = 1'b0;
    w_push_entry   = '0;

    case (r_state)
      HUNT: begin
        w_hist_nx = w_hist_shift;
        if (w_hist_shift == C_PRE_IMAGE) begin
          w_state_nx = DATA;
          w_slot_nx  = '0;
          w_sym_nx   = '0;
          w_eras_nx  = '0;
        end
      end

      DATA: begin
        // Strict compare keeps the lowest slot index on ties.
        if (w_on && (!w_base_have || (num_in > w_base_val))) begin
          w_have_nx     = 1'b1;
          w_best_val_nx = num_in;
          w_best_idx_nx = r_slot_cnt;
        end

        if (r_slot_cnt == C_LAST_SLOT) begin
          w_push             = 1'b1;
          w_slot_nx          = '0;
          w_push_entry.erase = !w_have_nx;
          w_push_entry.sym   = w_have_nx ? w_best_idx_nx : '0;
          w_sym_nx           = r_sym_cnt + 1'b1;
          w_eras_nx          = w_have_nx ? '0 : r_eras_cnt + 1'b1;

          // Loss of lock takes priority over a frame completing.
          if (!w_have_nx && (r_eras_cnt == C_LAST_ERAS)) begin
            w_state_nx = HUNT;
            w_hist_nx  = '0;
          end else if (r_sym_cnt == C_LAST_SYM) begin
            w_frame_end_nx = 1'b1;
            w_state_nx     = HUNT;
            w_hist_nx      = '0;
          end
        end else begin
          w_slot_nx = r_slot_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nx = HUNT;
      end
    endcase
  end

  rx_sym_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk10m     (clk10m),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_data     (w_push_entry),
    .i_ready    (sym_ready),
    .o_head     (w_head),
    .o_valid    (sym_valid),
    .o_overflow (overflow)
  );

  assign sym_data  = w_head.sym;
  assign sym_erase = w_head.erase;
  assign locked    = (r_state == DATA);
  assign frame_end = r_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_rx_ppm_slot_demod.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_ppm_slot_demod
// Description : Self-checking bench for rx_ppm_slot_demod. A table of symbol
//               vectors (five slot counts, window sum, expected symbol) is
//               applied inside a locked frame; hand-written sequences cover
//               lock timing, erasures, overflow and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rx_ppm_slot_demod;
  import rx_ppm_pkg::*;

  logic             clk10m = 1'b0;
  logic             rst_n;
  logic [6:0]       num_in;
  logic [12:0]      num_sum_in;
  logic [SYM_W-1:0] sym_data;
  logic             sym_erase;
  logic             sym_valid;
  logic             sym_ready;
  logic             locked;
  logic             frame_end;
  logic             overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #50 clk10m = ~clk10m;

  rx_ppm_slot_demod dut (
    .clk10m     (clk10m),
    .rst_n      (rst_n),
    .num_in     (num_in),
    .num_sum_in (num_sum_in),
    .sym_data   (sym_data),
    .sym_erase  (sym_erase),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .locked     (locked),
    .frame_end  (frame_end),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [4:0][6:0] slots;   // slots[i] is the count for slot i
    logic [12:0]     sum;
    logic [2:0]      sym;
    logic            erase;
    logic            fend;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                              input int s4, input int sum, input int sym,
                              input int erase, input int fend);
    vec_t v;
    v.slots[0] = 7'(s0);
    v.slots[1] = 7'(s1);
    v.slots[2] = 7'(s2);
    v.slots[3] = 7'(s3);
    v.slots[4] = 7'(s4);
    v.sum      = 13'(sum);
    v.sym      = 3'(sym);
    v.erase    = 1'(erase);
    v.fend     = 1'(fend);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one slot sample between edges, then sample just after the edge.
  task automatic step(input int n, input int sum);
    @(negedge clk10m);
    num_in     = 7'(n);
    num_sum_in = 13'(sum);
    @(posedge clk10m);
    #1;
  endtask

  // s < 0 sends an all-off symbol.
  task automatic send_sym(input int s);
    for (int i = 0; i < 5; i++) begin
      step((i == s) ? 40 : 2, 2500);
    end
  endtask

  task automatic send_pre();
    send_sym(0);
    send_sym(4);
    send_sym(2);
    send_sym(1);
  endtask

  task automatic do_reset();
    @(negedge clk10m);
    rst_n      = 1'b0;
    num_in     = 7'd2;
    num_sum_in = 13'd2500;
    @(posedge clk10m);
    #1;
    @(negedge clk10m);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = mk( 2,  2,  2, 40,  2, 2500, 3, 0, 0);
    vecs[1] = mk( 2, 40,  2,  2,  2, 2500, 1, 0, 0);
    vecs[2] = mk( 2, 40,  2, 40,  2, 2500, 1, 0, 0);   // tie -> lowest index
    vecs[3] = mk( 2, 30,  2, 50,  2, 2500, 3, 0, 0);
    vecs[4] = mk(10, 10, 10, 10, 10, 2500, 0, 1, 0);   // equality is off
    vecs[5] = mk( 3,  4,  2,  2,  2,  500, 1, 0, 0);   // slot0 under floor
    vecs[6] = mk(50, 49,  2,  2, 60, 2500, 4, 0, 0);
    vecs[7] = mk( 2,  2, 40,  2,  2, 2500, 2, 0, 1);   // 8th symbol ends frame

    rst_n      = 1'b0;
    num_in     = 7'd0;
    num_sum_in = 13'd0;
    sym_ready  = 1'b0;
    repeat (2) @(posedge clk10m);
    #1;
    check("rst sym_valid", 32'(sym_valid), 0);
    check("rst sym_data",  32'(sym_data),  0);
    check("rst sym_erase", 32'(sym_erase), 0);
    check("rst locked",    32'(locked),    0);
    check("rst frame_end", 32'(frame_end), 0);
    check("rst overflow",  32'(overflow),  0);
    @(negedge clk10m);
    rst_n = 1'b1;

    // Average-level samples never count as on, so no lock can occur.
    for (int i = 0; i < 25; i++) step(10, 2500);
    check("flat no lock", 32'(locked), 0);

    // Lock timing and two data symbols with 1-cycle output latency.
    sym_ready = 1'b1;
    send_sym(0);
    send_sym(4);
    send_sym(2);
    step(2, 2500); step(40, 2500); step(2, 2500); step(2, 2500);
    check("lock after 19", 32'(locked), 0);
    step(2, 2500);
    check("lock after 20", 32'(locked), 1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) step((i == 3 - 2*k) ? 40 : 2, 2500);
      check("pre-push valid", 32'(sym_valid), 0);
      step(2, 2500);
      check("data valid", 32'(sym_valid), 1);
      check("data sym",   32'(sym_data),  (k == 0) ? 3 : 1);
      check("data erase", 32'(sym_erase), 0);
    end
    step(2, 2500);
    check("popped valid", 32'(sym_valid), 0);

    // Table-driven frame of 8 symbols.
    do_reset();
    send_pre();
    check("tbl lock", 32'(locked), 1);
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 5; i++) step(int'(vecs[v].slots[i]), int'(vecs[v].sum));
      check("tbl valid",     32'(sym_valid), 1);
      check("tbl sym",       32'(sym_data),  32'(vecs[v].sym));
      check("tbl erase",     32'(sym_erase), 32'(vecs[v].erase));
      check("tbl frame_end", 32'(frame_end), 32'(vecs[v].fend));
      check("tbl locked",    32'(locked),    32'(!vecs[v].fend));
    end
    step(2, 2500);
    check("frame_end pulse", 32'(frame_end), 0);
    send_pre();
    check("relock", 32'(locked), 1);

    // Three consecutive erasures drop lock.
    for (int k = 0; k < 3; k++) begin
      if (k == 2) check("lock before 3rd eras", 32'(locked), 1);
      send_sym(-1);
      check("eras erase", 32'(sym_erase), 1);
      check("eras sym",   32'(sym_data),  0);
      check("eras valid", 32'(sym_valid), 1);
    end
    check("eras unlock",    32'(locked),    0);
    check("eras no fend",   32'(frame_end), 0);

    // Overflow with consumer stalled, then ordered drain.
    do_reset();
    sym_ready = 1'b0;
    send_pre();
    for (int k = 0; k < 6; k++) begin
      send_sym(k % 5);
      if (k == 3) check("ovf before full", 32'(overflow), 0);
      if (k == 4) check("ovf set",         32'(overflow), 1);
    end
    sym_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain valid", 32'(sym_valid), 1);
      check("drain sym",   32'(sym_data),  k);
      step(2, 2500);
    end
    check("drain empty",  32'(sym_valid), 0);
    check("ovf sticky",   32'(overflow),  1);
    check("drain locked", 32'(locked),    1);

    // Reset in DATA with two queued symbols discards everything.
    do_reset();
    sym_ready = 1'b0;
    send_pre();
    send_sym(2);
    send_sym(3);
    check("queued valid", 32'(sym_valid), 1);
    step(40, 2500);
    @(negedge clk10m);
    rst_n = 1'b0;
    @(posedge clk10m);
    #1;
    check("midrst valid",  32'(sym_valid), 0);
    check("midrst sym",    32'(sym_data),  0);
    check("midrst erase",  32'(sym_erase), 0);
    check("midrst locked", 32'(locked),    0);
    check("midrst fend",   32'(frame_end), 0);
    check("midrst ovf",    32'(overflow),  0);
    @(negedge clk10m);
    rst_n = 1'b1;
    step(2, 2500);
    step(2, 2500);
    check("post-rst valid", 32'(sym_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
